axis_sequencer: RTL and testbench

Per-axis command sequencer that sits directly upstream of the forward and backward stepper movers. It accepts absolute target positions or home requests, converts each into a direction and step count, and runs the go/done handshake with the correct mover. It tracks the axis position and hands the last coil state back to both movers, so the coil sequence never jumps between moves.

---
 rtl/axis_sequencer_pkg.sv | 20 ++
 rtl/axis_sequencer.sv | 178 +++++++++++++++++
 tb/tb_axis_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_sequencer_pkg.sv
// axis_sequencer_pkg
//   Shared definitions for the per-axis command sequencer:
//   - coil reset pattern handed to the movers after reset
//   - sequencer state encoding
//   - default travel limit and homing step budget
package axis_sequencer_pkg;

    localparam logic [3:0]  COIL_RESET     = 4'b1100;
    localparam logic [11:0] DEF_MAX_POS    = 12'd2000;
    localparam logic [11:0] DEF_HOME_STEPS = 12'd4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_FWD,
        ST_RUN_BWD,
        ST_HOME,
        ST_RELEASE
    } seq_state_e;

endpackage

// File: rtl/axis_sequencer.sv
// axis_sequencer
//   Converts absolute target / home commands into a direction plus step
//   count, runs the go/done handshake with the forward or backward mover,
//   tracks axis position and hands the last coil state back to both movers.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/ready/home/target command interface (accepted in IDLE only)
//   fwd_go, bwd_go, steps      request to forward / backward mover
//   fwd_done, bwd_done         mover completion
//   fwd_state, bwd_state       mover coil states
//   old_state                  last coil state, returned to both movers
//   bound_lo, bound_hi         synchronised end-stop switches
//   position, lost             axis position and position-unknown flag
//   move_done, cmd_err         one-cycle completion / reject pulses
module axis_sequencer
    import axis_sequencer_pkg::*;
#(
    parameter logic [11:0] MAX_POS    = DEF_MAX_POS,
    parameter logic [11:0] HOME_STEPS = DEF_HOME_STEPS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_home,
    input  logic [11:0] cmd_target,
    output logic        fwd_go,
    output logic        bwd_go,
    output logic [11:0] steps,
    input  logic        fwd_done,
    input  logic        bwd_done,
    input  logic [3:0]  fwd_state,
    input  logic [3:0]  bwd_state,
    output logic [3:0]  old_state,
    input  logic        bound_lo,
    input  logic        bound_hi,
    output logic [11:0] position,
    output logic        lost,
    output logic        move_done,
    output logic        cmd_err
);

    seq_state_e  state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        fwd_go_q, fwd_go_d;
    logic        bwd_go_q, bwd_go_d;
    logic [11:0] steps_q, steps_d;
    logic [3:0]  old_state_q, old_state_d;
    logic [11:0] position_q, position_d;
    logic [11:0] target_q, target_d;
    logic        lost_q, lost_d;
    logic        move_done_q, move_done_d;
    logic        cmd_err_q, cmd_err_d;

    always_comb begin
        state_d     = state_q;
        fwd_go_d    = fwd_go_q;
        bwd_go_d    = bwd_go_q;
        steps_d     = steps_q;
        old_state_d = old_state_q;
        position_d  = position_q;
        target_d    = target_q;
        lost_d      = lost_q;
        move_done_d = 1'b0;
        cmd_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_home) begin
                        steps_d  = HOME_STEPS;
                        bwd_go_d = 1'b1;
                        state_d  = ST_HOME;
                    end else if (lost_q || (cmd_target > MAX_POS)) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_target == position_q) begin
                        move_done_d = 1'b1;
                    end else if (cmd_target > position_q) begin
                        steps_d  = cmd_target - position_q;
                        target_d = cmd_target;
                        fwd_go_d = 1'b1;
                        state_d  = ST_RUN_FWD;
                    end else begin
                        steps_d  = position_q - cmd_target;
                        target_d = cmd_target;
                        bwd_go_d = 1'b1;
                        state_d  = ST_RUN_BWD;
                    end
                end
            end
            ST_RUN_FWD: begin
                if (fwd_done) begin
                    fwd_go_d    = 1'b0;
                    old_state_d = fwd_state;
                    // End-stop hit in the direction of travel: move was cut short.
                    if (bound_hi) lost_d     = 1'b1;
                    else          position_d = target_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_RUN_BWD: begin
                if (bwd_done) begin
                    bwd_go_d    = 1'b0;
                    old_state_d = bwd_state;
                    if (bound_lo) lost_d     = 1'b1;
                    else          position_d = target_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_HOME: begin
                if (bwd_done) begin
                    bwd_go_d    = 1'b0;
                    old_state_d = bwd_state;
                    if (bound_lo) begin
                        position_d = '0;
                        lost_d     = 1'b0;
                    end else begin
                        lost_d = 1'b1;
                    end
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for both movers to drop done so they have reloaded old_state.
                if (!fwd_done && !bwd_done) begin
                    move_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                fwd_go_d = 1'b0;
                bwd_go_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            fwd_go_q    <= 1'b0;
            bwd_go_q    <= 1'b0;
            steps_q     <= '0;
            old_state_q <= COIL_RESET;
            position_q  <= '0;
            target_q    <= '0;
            lost_q      <= 1'b1;
            move_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            fwd_go_q    <= fwd_go_d;
            bwd_go_q    <= bwd_go_d;
            steps_q     <= steps_d;
            old_state_q <= old_state_d;
            position_q  <= position_d;
            target_q    <= target_d;
            lost_q      <= lost_d;
            move_done_q <= move_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign fwd_go    = fwd_go_q;
    assign bwd_go    = bwd_go_q;
    assign steps     = steps_q;
    assign old_state = old_state_q;
    assign position  = position_q;
    assign lost      = lost_q;
    assign move_done = move_done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_axis_sequencer.sv
// tb_axis_sequencer
//   Drives axis_sequencer with directed and random commands, acting as both
//   movers and the end-stop switches, and compares every response against a
//   command-level model of axis position, lost flag and last coil state.
module tb_axis_sequencer;

    localparam int K_REJ  = 0;
    localparam int K_SAME = 1;
    localparam int K_FWD  = 2;
    localparam int K_BWD  = 3;
    localparam int K_HOME = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_home;
    logic [11:0] cmd_target;
    logic        fwd_go, bwd_go;
    logic [11:0] steps;
    logic        fwd_done, bwd_done;
    logic [3:0]  fwd_state, bwd_state;
    logic [3:0]  old_state;
    logic        bound_lo, bound_hi;
    logic [11:0] position;
    logic        lost;
    logic        move_done;
    logic        cmd_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Command-level model of the axis
    logic [11:0] m_pos;
    logic        m_lost;
    logic [3:0]  m_old;

    axis_sequencer #(.MAX_POS(12'd2000), .HOME_STEPS(12'd4095)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_home(cmd_home), .cmd_target(cmd_target),
        .fwd_go(fwd_go), .bwd_go(bwd_go), .steps(steps),
        .fwd_done(fwd_done), .bwd_done(bwd_done),
        .fwd_state(fwd_state), .bwd_state(bwd_state),
        .old_state(old_state),
        .bound_lo(bound_lo), .bound_hi(bound_hi),
        .position(position), .lost(lost),
        .move_done(move_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("one_go", {31'd0, fwd_go & bwd_go}, 32'd0);
            chk("pulse_excl", {31'd0, move_done & cmd_err}, 32'd0);
        end
    end

    task automatic model_reset();
        m_pos  = '0;
        m_lost = 1'b1;
        m_old  = 4'b1100;
    endtask

    task automatic chk_axis(input string tag);
        chk({tag, "_pos"},  {20'd0, position}, {20'd0, m_pos});
        chk({tag, "_lost"}, {31'd0, lost}, {31'd0, m_lost});
        chk({tag, "_old"},  {28'd0, old_state}, {28'd0, m_old});
    endtask

    // Issue one command at a negedge and play the mover side until done.
    // dly: cycles of go before done; hit: end-stop in travel direction at done;
    // extra: cycles done stays high after go drops (>=1).
    task automatic do_cmd(input bit home, input logic [11:0] tgt, input bit hit,
                          input int unsigned dly, input int unsigned extra);
        int          kind;
        logic [11:0] exp_steps;
        logic [3:0]  fs, bs;
        bit          fwd;

        exp_steps = '0;
        if (home) begin
            kind = K_HOME; exp_steps = 12'd4095;
        end else if (m_lost || tgt > 12'd2000) begin
            kind = K_REJ;
        end else if (tgt == m_pos) begin
            kind = K_SAME;
        end else if (tgt > m_pos) begin
            kind = K_FWD; exp_steps = tgt - m_pos;
        end else begin
            kind = K_BWD; exp_steps = m_pos - tgt;
        end
        fwd = (kind == K_FWD);

        chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_home   = home;
        cmd_target = tgt;
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_home   = 1'($urandom);
        cmd_target = 12'($urandom);

        if (kind == K_REJ || kind == K_SAME) begin
            chk("err_pulse",  {31'd0, cmd_err},   {31'd0, kind == K_REJ});
            chk("done_pulse", {31'd0, move_done}, {31'd0, kind == K_SAME});
            chk("no_go",      {30'd0, fwd_go, bwd_go}, 32'd0);
            @(negedge clk);
            chk("pulse_clr",  {30'd0, cmd_err, move_done}, 32'd0);
            chk("ready_back", {31'd0, cmd_ready}, 32'd1);
            chk_axis("imm");
            return;
        end

        chk("fwd_go", {31'd0, fwd_go}, {31'd0, fwd});
        chk("bwd_go", {31'd0, bwd_go}, {31'd0, !fwd});
        chk("steps",  {20'd0, steps}, {20'd0, exp_steps});
        chk("old_at_go", {28'd0, old_state}, {28'd0, m_old});
        chk("ready_busy", {31'd0, cmd_ready}, 32'd0);

        for (int unsigned i = 0; i < dly; i++) begin
            // Commands offered while busy must be ignored.
            cmd_valid  = 1'($urandom);
            cmd_home   = 1'($urandom);
            cmd_target = 12'($urandom);
            fwd_state  = 4'($urandom);
            bwd_state  = 4'($urandom);
            @(negedge clk);
            chk("go_hold", {30'd0, fwd_go, bwd_go}, fwd ? 32'd2 : 32'd1);
            chk("steps_hold", {20'd0, steps}, {20'd0, exp_steps});
        end

        cmd_valid = 1'b0;
        fs = 4'($urandom);
        bs = 4'($urandom);
        fwd_state = fs;
        bwd_state = bs;
        if (fwd) begin fwd_done = 1'b1; bound_hi = hit; end
        else     begin bwd_done = 1'b1; bound_lo = hit; end

        m_old = fwd ? fs : bs;
        if (kind == K_HOME) begin
            if (hit) begin m_pos = '0; m_lost = 1'b0; end
            else     m_lost = 1'b1;
        end else begin
            if (hit) m_lost = 1'b1;
            else     m_pos = tgt;
        end

        @(negedge clk);
        chk("go_drop", {30'd0, fwd_go, bwd_go}, 32'd0);
        chk_axis("run");
        chk("no_early_done", {31'd0, move_done}, 32'd0);
        bound_hi  = 1'b0;
        bound_lo  = 1'b0;
        fwd_state = 4'($urandom);
        bwd_state = 4'($urandom);
        for (int unsigned i = 1; i < extra; i++) begin
            @(negedge clk);
            chk("rel_wait", {31'd0, move_done}, 32'd0);
        end
        fwd_done = 1'b0;
        bwd_done = 1'b0;
        @(negedge clk);
        chk("move_done", {31'd0, move_done}, 32'd1);
        chk("ready_ret", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("move_done_clr", {31'd0, move_done}, 32'd0);
        chk_axis("post");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_gos"},   {30'd0, fwd_go, bwd_go}, 32'd0);
        chk({tag, "_steps"}, {20'd0, steps}, 32'd0);
        chk({tag, "_pulses"}, {30'd0, move_done, cmd_err}, 32'd0);
        chk_axis(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_home = 1'b0; cmd_target = '0;
        fwd_done = 1'b0; bwd_done = 1'b0;
        fwd_state = 4'h3; bwd_state = 4'h6;
        bound_lo = 1'b0; bound_hi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios
        do_cmd(1'b0, 12'd100, 1'b0, 1, 1);      // rejected: lost after reset
        do_cmd(1'b1, 12'd0,   1'b1, 37, 1);     // home, bound_lo after 37 steps
        do_cmd(1'b0, 12'd250, 1'b0, 5, 2);
        do_cmd(1'b0, 12'd100, 1'b0, 4, 1);
        do_cmd(1'b0, 12'd2001, 1'b0, 1, 1);     // beyond MAX_POS
        do_cmd(1'b0, 12'd2000, 1'b0, 3, 1);     // exactly MAX_POS
        do_cmd(1'b0, 12'd2000, 1'b0, 1, 1);     // target equals position
        do_cmd(1'b0, 12'd0,    1'b0, 2, 3);
        do_cmd(1'b0, 12'd500,  1'b1, 20, 1);    // bound_hi cuts move short
        do_cmd(1'b0, 12'd10,   1'b0, 1, 1);     // rejected while lost
        do_cmd(1'b1, 12'd0,    1'b0, 6, 1);     // home without end-stop: still lost
        do_cmd(1'b1, 12'd0,    1'b1, 9, 2);
        do_cmd(1'b0, 12'd300,  1'b0, 3, 1);
        do_cmd(1'b0, 12'd200,  1'b1, 4, 1);     // bound_lo cuts backward move
        do_cmd(1'b1, 12'd0,    1'b1, 2, 1);

        // Reset in the middle of a forward move
        cmd_valid = 1'b1; cmd_home = 1'b0; cmd_target = 12'd700;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_fwd_go", {31'd0, fwd_go}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_reset_vals("midrst");
        @(negedge clk);
        do_cmd(1'b0, 12'd5, 1'b0, 1, 1);        // rejected after reset

        // Random commands
        for (int n = 0; n < 80; n++) begin
            bit          h;
            logic [11:0] t;
            h = ($urandom_range(99, 0) < 20);
            if ($urandom_range(9, 0) == 0) t = m_pos;
            else                           t = 12'($urandom_range(2100, 0));
            do_cmd(h, t,
                   h ? ($urandom_range(99, 0) < 85) : ($urandom_range(9, 0) == 0),
                   $urandom_range(25, 1), $urandom_range(3, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
